// File: rtl/sync_fifo_buf_if.sv
// Handshake and status bundle for the single-clock FIFO buffer.
// The master side is the producer/consumer; the slave side is the FIFO.
interface sync_fifo_buf_if #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4
);
  logic                clr;
  logic                wen;
  logic [DATASIZE-1:0] din;
  logic                ren;
  logic [DATASIZE-1:0] dout;
  logic                dout_valid;
  logic                fifo_full;
  logic                fifo_empty;
  logic                almost_full;
  logic                almost_empty;
  logic [ADDRSIZE:0]   count;
  logic                overflow;
  logic                underflow;

  modport master (
    output clr, wen, din, ren,
    input  dout, dout_valid, fifo_full, fifo_empty,
    input  almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  clr, wen, din, ren,
    output dout, dout_valid, fifo_full, fifo_empty,
    output almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_buf.sv
// Single-clock FIFO with registered read port, occupancy count, threshold
// flags, synchronous flush and sticky overflow/underflow indicators.
module sync_fifo_buf #(
  parameter int DATASIZE  = 8,
  parameter int ADDRSIZE  = 4,
  parameter int AFULL_TH  = (1 << ADDRSIZE) - 2,
  parameter int AEMPTY_TH = 2
) (
  input logic           clk_i,
  input logic           rst_n,
  sync_fifo_buf_if.slave bus
);
  localparam int DEPTH = 1 << ADDRSIZE;
  localparam logic [ADDRSIZE:0] PTR_ONE   = {{ADDRSIZE{1'b0}}, 1'b1};
  localparam logic [ADDRSIZE:0] AFULL_LV  = AFULL_TH[ADDRSIZE:0];
  localparam logic [ADDRSIZE:0] AEMPTY_LV = AEMPTY_TH[ADDRSIZE:0];

  logic [DATASIZE-1:0] mem [DEPTH];
  logic [ADDRSIZE:0]   wr_ptr;
  logic [ADDRSIZE:0]   rd_ptr;
  logic [ADDRSIZE:0]   count;
  logic                full;
  logic                empty;
  logic                wr_acc;
  logic                rd_acc;
  logic [DATASIZE-1:0] dout_q;
  logic                dout_valid_q;
  logic                overflow_q;
  logic                underflow_q;

  // Status is a pure decode of the registered pointers; the wrap bit
  // distinguishes full from empty when the memory indices coincide.
  always_comb begin
    count = wr_ptr - rd_ptr;
    full  = (wr_ptr[ADDRSIZE] != rd_ptr[ADDRSIZE]) &&
            (wr_ptr[ADDRSIZE-1:0] == rd_ptr[ADDRSIZE-1:0]);
    empty = (wr_ptr == rd_ptr);
  end

  // Flush blocks both accesses so memory and dout stay untouched.
  assign wr_acc = bus.wen & ~full  & ~bus.clr;
  assign rd_acc = bus.ren & ~empty & ~bus.clr;

  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      mem[wr_ptr[ADDRSIZE-1:0]] <= bus.din;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      dout_valid_q <= rd_acc;
      if (rd_acc) begin
        dout_q <= mem[rd_ptr[ADDRSIZE-1:0]];
      end
      if (bus.clr) begin
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        overflow_q  <= 1'b0;
        underflow_q <= 1'b0;
      end else begin
        if (wr_acc) begin
          wr_ptr <= wr_ptr + PTR_ONE;
        end
        if (rd_acc) begin
          rd_ptr <= rd_ptr + PTR_ONE;
        end
        if (bus.wen && full) begin
          overflow_q <= 1'b1;
        end
        if (bus.ren && empty) begin
          underflow_q <= 1'b1;
        end
      end
    end
  end

  assign bus.dout         = dout_q;
  assign bus.dout_valid   = dout_valid_q;
  assign bus.fifo_full    = full;
  assign bus.fifo_empty   = empty;
  assign bus.almost_full  = (count >= AFULL_LV);
  assign bus.almost_empty = (count <= AEMPTY_LV);
  assign bus.count        = count;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: doc/sync_fifo_buf.md
# sync_fifo_buf

Single-clock, parametrised FIFO buffer that succeeds the bare FIFO memory array. It adds its own pointer management, a registered read port with a valid strobe, an occupancy count, programmable almost-full and almost-empty thresholds, a synchronous flush, and sticky overflow/underflow error flags. It is used wherever producer and consumer share one clock domain, for example in the checker and scoreboard data paths and in single-domain staging ahead of the async FIFO.

## Interface
Parameters:
- DATASIZE, 8: data word width in bits.
- ADDRSIZE, 4: address width in bits; DEPTH = 2**ADDRSIZE entries.
- AFULL_TH, DEPTH-2: almost_full asserts when count >= AFULL_TH.
- AEMPTY_TH, 2: almost_empty asserts when count <= AEMPTY_TH.

Ports:
- clk_i, input, 1: the single clock. All state changes on its rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- clr, input, 1: synchronous flush.
- wen, input, 1: write request.
- din, input, DATASIZE: write data.
- ren, input, 1: read request.
- dout, output, DATASIZE: registered read data.
- dout_valid, output, 1: one-cycle strobe; dout holds newly read data.
- fifo_full, output, 1: count == DEPTH.
- fifo_empty, output, 1: count == 0.
- almost_full, output, 1: threshold flag as defined by AFULL_TH.
- almost_empty, output, 1: threshold flag as defined by AEMPTY_TH.
- count, output, ADDRSIZE+1: current occupancy, 0..DEPTH.
- overflow, output, 1: sticky; a write was attempted while full.
- underflow, output, 1: sticky; a read was attempted while empty.

## Operation
- Pointers:
  - wr_ptr and rd_ptr are ADDRSIZE+1 bits wide. The memory index is the low ADDRSIZE bits. The MSB is the wrap bit.
  - count = wr_ptr - rd_ptr, modulo 2**(ADDRSIZE+1).
  - fifo_full: pointer MSBs differ and low bits are equal. fifo_empty: pointers are equal.
- Write acceptance (wr_acc): wen & ~fifo_full.
  - On wr_acc, mem[wr_ptr low bits] <= din and wr_ptr increments.
  - A rejected write leaves memory and pointer unchanged.
- Read acceptance (rd_acc): ren & ~fifo_empty.
  - On rd_acc, dout <= mem[rd_ptr low bits], rd_ptr increments, and dout_valid is 1 in the next cycle.
  - When there is no rd_acc, dout holds its previous value (never X) and dout_valid is 0.
- Full and empty are evaluated on the pre-edge state:
  - wen & ren while full: the read is accepted, the write is rejected, overflow sets, and count becomes DEPTH-1.
  - wen & ren while empty: the write is accepted, the read is rejected, underflow sets, and count becomes 1.
  - wen & ren at any other occupancy: both are accepted and count is unchanged.
  - Read-during-write never aliases: when both are accepted the pointers differ, so the read returns the old entry.
- Error flags: overflow sets on wen & fifo_full; underflow sets on ren & fifo_empty. Both stay set until clr or reset.
- clr has priority over wen and ren in the same cycle. It:
  - zeroes both pointers;
  - clears overflow and underflow;
  - forces dout_valid to 0;
  - leaves dout and memory contents unchanged.
- Status flags and count are combinational decodes of the registered pointers. They are glitch-free relative to clk_i.
- Memory is not reset. Data is only observable after it has been written.

## Timing
- Reset (asynchronous, rst_n = 0):
  - wr_ptr = rd_ptr = 0.
  - dout = 0, dout_valid = 0.
  - overflow = underflow = 0.
  - Resulting outputs: fifo_empty = 1, fifo_full = 0, count = 0, almost_empty = 1, almost_full = 0.
  - The block exits reset on the first rising edge after rst_n deasserts.
- Write to visibility: data written at edge N raises count and clears fifo_empty immediately after edge N. A read can be accepted at edge N+1.
- Read latency: ren accepted at edge N puts the data on dout with dout_valid = 1 after edge N, so the consumer samples both at edge N+1.
- Back-to-back reads deliver one word per cycle with dout_valid held high.
- Flags update in the same cycle as the pointer edge that changes them; there is no extra pipeline delay.
- Reset asserted mid-operation takes effect immediately, regardless of clk_i. Any in-flight read is discarded (dout_valid = 0).
- Wrap-around: after 2**(ADDRSIZE+1) accepted writes, wr_ptr returns to 0 with no disturbance to count or flags.

## Test plan
Default parameters: DATASIZE = 8, ADDRSIZE = 4, DEPTH = 16, AFULL_TH = 14, AEMPTY_TH = 2.
- Reset, fill, drain: release reset, write 0x00..0x0F, then read 16 words.
  - fifo_full is 1 after the 16th write.
  - dout_valid pulses return 0x00..0x0F in order, each one cycle after its ren.
  - fifo_empty is 1 again and neither error flag is set.
- Thresholds: write 14 words, then read 12.
  - almost_full rises exactly when count reaches 14.
  - almost_empty rises when count falls to 2.
- Simultaneous read and write at the boundaries:
  - Full, wen & ren: count becomes 15, overflow = 1, and the last written word is not lost.
  - Empty, wen & ren: count becomes 1, underflow = 1, dout_valid stays 0.
- Steady streaming with wrap: at occupancy 5, run wen & ren for 40 cycles.
  - count stays 5.
  - The output sequence equals the input sequence delayed by 5 words.
  - The pointers wrap through 31 to 0 cleanly.
- Flush: at count = 9 with overflow set, assert clr together with wen & ren.
  - Next cycle: count = 0, fifo_empty = 1, overflow = 0, dout_valid = 0, dout unchanged.
- Asynchronous reset mid-read: drop rst_n between edges while reads are streaming.
  - Outputs go to reset values immediately: dout = 0, count = 0.
  - After release, a fresh write/read returns correct data.
